msg_csr_bank: RTL
=================

Name: msg_csr_bank

Overview:
Multi-channel Avalon-MM control/status register bank for the AES message datapath. It generalises the single-channel word-count controller to NUM_CH channels. Each channel has a word-count config with a start pulse, two readback counters, and a busy/done/overflow status. A global interrupt enable and pending pair drives a single level irq to the host.

Parameters:
NUM_CH, 4, number of message channels (1..8)
WORD_W, 8, width of per-channel word count and counters (1..32)
ADDR_W, 8, Avalon byte-address width used for decode (upper bits ignored)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mm_address  in  32  byte address; bits [ADDR_W-1:0] decoded
mm_writedata  in  32  write data
mm_write  in  1  write request
mm_read  in  1  read request
mm_readdata  out  32  read data
mm_readdatavalid  out  1  read data valid
mm_waitrequest  out  1  slave not ready
msg_words_out  out  NUM_CH*WORD_W  per-channel configured word count, ch0 in LSBs
msg_start  out  NUM_CH  one-cycle start pulse per channel
msg_words_in_remover  in  NUM_CH*WORD_W  per-channel remover word counter
msg_words_in_adder  in  NUM_CH*WORD_W  per-channel adder word counter
ch_done  in  NUM_CH  one-cycle per-channel completion pulse
irq  out  1  level interrupt, high while any enabled done is pending

Behaviour:
- Reset: rst sampled on clk edge, synchronous only. All outputs 0 except mm_waitrequest=1. All registers 0: conf, busy, done, ovf, irq_en. Reset mid-transaction drops any pending readdatavalid.
- mm_waitrequest is 1 during reset and 0 from the first cycle after rst deasserts; it is never reasserted. There is no back-pressure.
- Address map: channel c base = c*0x10.
  - +0x0 CONF: RW, WORD_W bits.
  - +0x4 REMOVER: RO.
  - +0x8 ADDER: RO.
  - +0xC STATUS: bit0 busy RO, bit1 done W1C, bit2 ovf W1C.
  - 0xF0 IRQ_EN: RW, NUM_CH bits.
  - 0xF4 IRQ_PEND: RO, done & irq_en.
- Decode: addresses with bits[1:0]!=0, channels >= NUM_CH, or no map entry are unmapped. Unmapped writes are ignored. Unmapped reads return 32'hFFFF_FFFF.
- Read latency: mm_readdatavalid=1 exactly one cycle after mm_read is sampled, for one cycle. mm_readdata holds valid data that cycle and is 0 otherwise. Fields are zero-extended to 32 bits.
- CONF write, channel idle (busy=0):
  - conf <= writedata[WORD_W-1:0]; msg_words_out updates next cycle.
  - msg_start[c] pulses high for one cycle (same cycle as the conf update).
  - busy <= 1.
- CONF write, channel busy: rejected. conf unchanged, no start, ovf <= 1 (sticky).
- ch_done[c] pulse: busy <= 0, done <= 1. A ch_done while busy=0 still sets done.
- Same-cycle events on one channel:
  - ch_done and CONF write: done is processed first, so busy is 0 and the write is accepted as a fresh start. Both done=1 and busy=1 result.
  - Hardware set and W1C on the same bit: set wins (bit stays 1).
- W1C: writing 1 to STATUS bit1 or bit2 clears that bit. Writing 0 has no effect. bit0 is ignored on write.
- mm_read and mm_write in the same cycle: both are serviced. The read returns the pre-write value.
- irq = |(done & irq_en), registered; it asserts one cycle after the done or irq_en change.
- Counters on msg_words_in_* are sampled when the read is accepted, not latched beforehand.

Decomposition:
- Package msg_csr_pkg holds:
  - offset localparams: CONF_OFF=0x0, REMOVER_OFF=0x4, ADDER_OFF=0x8, STATUS_OFF=0xC, IRQ_EN_ADDR=0xF0, IRQ_PEND_ADDR=0xF4, CH_STRIDE=0x10;
  - STATUS bit indices;
  - the unmapped read value constant.
- Sub-module msg_csr_channel, instantiated NUM_CH times via generate. It owns conf, busy, done, ovf and msg_start, and takes decoded wr_conf/w1c strobes.
- The top owns address decode, the read mux and pipeline register, waitrequest, irq_en and irq.

Test Plan:
- Reset: hold rst 3 cycles -> mm_waitrequest=1, all outputs 0; cycle after release mm_waitrequest=0.
- Start: write 0x25 to 0x10 (ch1) -> next cycle msg_words_out[15:8]=0x25 and msg_start=4'b0010 for one cycle; read 0x1C -> readdata=0x1 one cycle later with readdatavalid.
- Overflow: while ch1 busy, write 0x40 to 0x10 -> no start, conf stays 0x25, STATUS reads 0x5. Write 0x4 to 0x1C -> reads 0x1.
- Done/irq: IRQ_EN=0x2, pulse ch_done[1] -> irq=1 next cycle, IRQ_PEND=0x2. Write 0x2 to 0x1C with another ch_done[1] in the same cycle -> done stays 1. Clear again -> irq=0.
- Counters/unmapped: drive adder ch2=0x7A and read 0x28 -> 0x0000007A. Read 0x42 (misaligned) and 0x40 with NUM_CH=4 -> 0xFFFFFFFF. Write to 0x44 -> no state change.
- Simultaneous: same-cycle CONF write and ch_done on a busy ch0 -> start pulse, busy=1, done=1. Assert rst mid-read -> no readdatavalid after reset.

Source files
------------

// File: rtl/msg_csr_pkg.sv
// Shared register map constants for the message-channel CSR bank.
package msg_csr_pkg;
  localparam logic [31:0] CONF_OFF      = 32'h0;
  localparam logic [31:0] REMOVER_OFF   = 32'h4;
  localparam logic [31:0] ADDER_OFF     = 32'h8;
  localparam logic [31:0] STATUS_OFF    = 32'hC;
  localparam logic [31:0] IRQ_EN_ADDR   = 32'hF0;
  localparam logic [31:0] IRQ_PEND_ADDR = 32'hF4;
  localparam logic [31:0] CH_STRIDE     = 32'h10;

  localparam int STS_BUSY_BIT = 0;
  localparam int STS_DONE_BIT = 1;
  localparam int STS_OVF_BIT  = 2;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/msg_csr_bank_if.sv
// Avalon-MM slave bus; the host drives the master side, the CSR bank the slave side.
interface msg_csr_bank_if;
  logic [31:0] mm_address;
  logic [31:0] mm_writedata;
  logic        mm_write;
  logic        mm_read;
  logic [31:0] mm_readdata;
  logic        mm_readdatavalid;
  logic        mm_waitrequest;

  modport master (
    output mm_address, mm_writedata, mm_write, mm_read,
    input  mm_readdata, mm_readdatavalid, mm_waitrequest
  );

  modport slave (
    input  mm_address, mm_writedata, mm_write, mm_read,
    output mm_readdata, mm_readdatavalid, mm_waitrequest
  );
endinterface

// File: rtl/msg_csr_channel.sv
// One message channel: word-count config, start pulse, busy/done/ovf status.
// All outputs registered; state changes land one cycle after the strobe.
module msg_csr_channel #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_conf,
  input  logic [WORD_W-1:0] conf_wdata,
  input  logic              w1c_done,
  input  logic              w1c_ovf,
  input  logic              ch_done,
  output logic [WORD_W-1:0] conf,
  output logic              msg_start,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  logic busy_eff;
  logic accept;
  logic reject;

  // A completion in the same cycle frees the channel before the write is judged.
  assign busy_eff = busy & ~ch_done;
  assign accept   = wr_conf & ~busy_eff;
  assign reject   = wr_conf & busy_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      conf      <= '0;
      msg_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      msg_start <= accept;
      if (accept) begin
        conf <= conf_wdata;
        busy <= 1'b1;
      end else if (ch_done) begin
        busy <= 1'b0;
      end
      // Hardware set takes priority over a software clear of the same bit.
      if (ch_done)       done <= 1'b1;
      else if (w1c_done) done <= 1'b0;
      if (reject)        ovf  <= 1'b1;
      else if (w1c_ovf)  ovf  <= 1'b0;
    end
  end
endmodule

// File: rtl/msg_csr_bank.sv
// Multi-channel Avalon-MM CSR bank: decode, read mux, one-cycle read pipeline, irq.
// Reads return one cycle after acceptance; waitrequest only covers reset.
module msg_csr_bank
  import msg_csr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  msg_csr_bank_if.slave            mm,
  output logic [NUM_CH*WORD_W-1:0] msg_words_out,
  output logic [NUM_CH-1:0]        msg_start,
  input  logic [NUM_CH*WORD_W-1:0] msg_words_in_remover,
  input  logic [NUM_CH*WORD_W-1:0] msg_words_in_adder,
  input  logic [NUM_CH-1:0]        ch_done,
  output logic                     irq
);
  logic              wait_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_nxt;
  logic [NUM_CH-1:0] irq_en;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       a32;
  logic [31:0]       ch32;
  logic [31:0]       off32;
  logic              ch_hit;
  logic              hit_irq_en;
  logic              hit_pend;
  logic              unused_bits;

  logic [WORD_W-1:0] conf_a [NUM_CH];
  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] done_v;
  logic [NUM_CH-1:0] ovf_v;

  assign mm.mm_waitrequest   = wait_q;
  assign mm.mm_readdatavalid = rvalid_q;
  assign mm.mm_readdata      = rdata_q;

  assign wr_en = mm.mm_write & ~wait_q;
  assign rd_en = mm.mm_read & ~wait_q;

  // Address bits above ADDR_W alias onto the decoded window.
  assign a32        = 32'(mm.mm_address[ADDR_W-1:0]);
  assign ch32       = a32 / CH_STRIDE;
  assign off32      = a32 % CH_STRIDE;
  assign ch_hit     = (a32[1:0] == 2'b00) && (ch32 < 32'(NUM_CH));
  assign hit_irq_en = (a32 == IRQ_EN_ADDR);
  assign hit_pend   = (a32 == IRQ_PEND_ADDR);
  assign unused_bits = ^{mm.mm_address, mm.mm_writedata};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    logic st_wr;
    assign sel   = ch_hit && (ch32 == 32'(g));
    assign st_wr = wr_en && sel && (off32 == STATUS_OFF);

    msg_csr_channel #(.WORD_W(WORD_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_conf    (wr_en && sel && (off32 == CONF_OFF)),
      .conf_wdata (mm.mm_writedata[WORD_W-1:0]),
      .w1c_done   (st_wr && mm.mm_writedata[STS_DONE_BIT]),
      .w1c_ovf    (st_wr && mm.mm_writedata[STS_OVF_BIT]),
      .ch_done    (ch_done[g]),
      .conf       (conf_a[g]),
      .msg_start  (msg_start[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .ovf        (ovf_v[g])
    );

    assign msg_words_out[g*WORD_W +: WORD_W] = conf_a[g];
  end

  always_comb begin
    rdata_nxt = UNMAPPED_RDATA;
    if (hit_irq_en) begin
      rdata_nxt = 32'(irq_en);
    end else if (hit_pend) begin
      rdata_nxt = 32'(done_v & irq_en);
    end else if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch32 == 32'(c)) begin
          case (off32)
            CONF_OFF:    rdata_nxt = 32'(conf_a[c]);
            REMOVER_OFF: rdata_nxt = 32'(msg_words_in_remover[c*WORD_W +: WORD_W]);
            ADDER_OFF:   rdata_nxt = 32'(msg_words_in_adder[c*WORD_W +: WORD_W]);
            STATUS_OFF: begin
              rdata_nxt               = '0;
              rdata_nxt[STS_BUSY_BIT] = busy_v[c];
              rdata_nxt[STS_DONE_BIT] = done_v[c];
              rdata_nxt[STS_OVF_BIT]  = ovf_v[c];
            end
            default:     rdata_nxt = UNMAPPED_RDATA;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      wait_q   <= 1'b0;
      rvalid_q <= rd_en;
      rdata_q  <= rd_en ? rdata_nxt : '0;
      if (wr_en && hit_irq_en) irq_en <= mm.mm_writedata[NUM_CH-1:0];
      irq      <= |(done_v & irq_en);
    end
  end
endmodule
